// File: rtl/mashdecim_if.sv
// Sample-in / reconstruction-out bundle for the mashdecim sinc^4 decimator.
// The bench drives through master; the decimator sits on slave.
interface mashdecim_if;
  logic [15:0] in_value;
  logic        in_valid;
  logic [31:0] out_value;
  logic        out_valid;
  logic        settled;

  // No back-pressure: a sample is taken on every rising edge with in_valid
  // high, and out_valid is a single-cycle pulse qualifying a new out_value.
  modport master (
    output in_value,
    output in_valid,
    input  out_value,
    input  out_valid,
    input  settled
  );

  modport slave (
    input  in_value,
    input  in_valid,
    output out_value,
    output out_valid,
    output settled
  );
endinterface

// File: rtl/mashdecim.sv
// 4th-order CIC (sinc^4) decimator, ratio 2^LOG2R, turning the 16-bit MASH
// sample stream back into a 16.16 estimate of the modulator target.
module mashdecim #(
  parameter int LOG2R = 4
) (
  input logic        clk,
  input logic        rst_n,
  mashdecim_if.slave bus
);
  localparam int W = 16 + 4 * LOG2R;

  logic [W-1:0]     i1, i2, i3, i4;
  logic [W-1:0]     i1_n, i2_n, i3_n, i4_n;
  logic [W-1:0]     d;
  logic [W-1:0]     z1, z2, z3, z4;
  logic [W-1:0]     c1, c2, c3, c4;
  logic [W-1:0]     x;
  logic [LOG2R-1:0] phase;
  logic             dv;
  logic [2:0]       out_cnt;
  logic [31:0]      out_value_r;
  logic             out_valid_r;
  logic             settled_r;

  // Integrators cascade on the freshly updated values; everything wraps mod 2^W,
  // which the combs undo exactly.
  always_comb begin
    x    = {{(W-16){1'b0}}, bus.in_value};
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    i4_n = i4 + i3_n;
    c1   = d - z1;
    c2   = c1 - z2;
    c3   = c2 - z3;
    c4   = c3 - z4;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i1          <= '0;
      i2          <= '0;
      i3          <= '0;
      i4          <= '0;
      d           <= '0;
      z1          <= '0;
      z2          <= '0;
      z3          <= '0;
      z4          <= '0;
      phase       <= '0;
      dv          <= 1'b0;
      out_cnt     <= 3'd0;
      out_value_r <= 32'd0;
      out_valid_r <= 1'b0;
      settled_r   <= 1'b0;
    end else begin
      dv          <= 1'b0;
      out_valid_r <= 1'b0;

      if (bus.in_valid) begin
        i1    <= i1_n;
        i2    <= i2_n;
        i3    <= i3_n;
        i4    <= i4_n;
        phase <= phase + LOG2R'(1);
        // Last sample of the block: hand the block's I4 to the comb section.
        if (&phase) begin
          d  <= i4_n;
          dv <= 1'b1;
        end
      end

      // Comb runs one edge after capture, overlapping the next block's intake.
      if (dv) begin
        z1          <= d;
        z2          <= c1;
        z3          <= c2;
        z4          <= c3;
        out_value_r <= c4[W-1 -: 32];
        out_valid_r <= 1'b1;
        if (out_cnt != 3'd4) out_cnt <= out_cnt + 3'd1;
        // The 4th output is the first one whose comb history is all real data.
        if (out_cnt >= 3'd3) settled_r <= 1'b1;
      end
    end
  end

  assign bus.out_value = out_value_r;
  assign bus.out_valid = out_valid_r;
  assign bus.settled   = settled_r;
endmodule

// File: doc/mashdecim.md
# mashdecim

Decimating reconstruction filter for the receive end of the 4-stage MASH modulator path. It accepts the 16-bit noise-shaped integer stream (one sample per `in_valid`) and applies a 4th-order CIC (sinc^4) decimator with decimation ratio R = 2^LOG2R. Each output is a 32-bit 16.16 fixed-point estimate of the original 32-bit target. It is used for loopback checking of the modulator and for recovering set-points at the far end of the modulated link.

## Interface
- LOG2R, default 4: log2 of the decimation ratio R; legal range 4..8.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low; overrides every other input.
- in_value  in  16  unsigned integer modulator sample.
- in_valid  in  1  sample strobe; `in_value` is accepted on any edge where this is high.
- out_value  out  32  16.16 unsigned reconstruction; held between updates.
- out_valid  out  1  one-cycle pulse marking a new `out_value`.
- settled  out  1  high once outputs are free of start-up transient.

## Operation
- Internal width W = 16 + 4*LOG2R (32 at default).
- All integrator and comb arithmetic is modulo 2^W with wrap-around, no saturation. Wrap is required for correctness.
- Integrators I1..I4 are W bits, reset to 0.
- On an accepted sample x, zero-extended to W, the integrators update as a same-edge cascade on new values:
  - I1' = I1 + x
  - I2' = I2 + I1'
  - I3' = I3 + I2'
  - I4' = I4 + I3'
- When `in_valid` is low, the integrators and the phase counter hold. Bubbles are invisible to the result.
- Phase counter `phase` is LOG2R bits, reset to 0, and increments per accepted sample. It wraps from R-1 to 0.
- On the accepted sample where `phase == R-1`, I4' is captured into decimation register D and a one-cycle internal flag `dv` is set.
- Comb section (differential delay M = 1) operates on the edge following `dv`:
  - C1 = D - Z1
  - C2 = C1 - Z2
  - C3 = C2 - Z3
  - C4 = C3 - Z4
  - Then Z1 <= D, Z2 <= C1, Z3 <= C2, Z4 <= C3.
  - Z1..Z4 reset to 0.
- Output: `out_value` <= C4[W-1 : W-32]. DC gain is R^4 = 2^(4*LOG2R), so the slice yields 16.16. At LOG2R = 4 this is C4[31:0] unmodified.
- Output counter: counts outputs 0..4 and saturates at 4. `settled` goes high on the edge that issues the 4th output, so it rises together with the 4th `out_valid`. It stays high until reset.
- From reset with constant input, the 4th and all later outputs are exact, because 4R - 4(R-1) >= 1. Outputs 1 to 3 are transient but fully deterministic.

## Timing
- Reset values:
  - `out_value` = 0, `out_valid` = 0, `settled` = 0.
  - `phase`, I1..I4, D, Z1..Z4, `dv` and the output counter are all 0.
- Latency: if the R-th sample of a block is accepted at the edge ending cycle t, then `out_valid` is high during cycle t+2 only.
- Throughput: one sample per clock. The maximum output rate is one pulse every R cycles, so `out_valid` is never high on consecutive cycles.
- A new block's samples may be accepted while the comb of the previous block is computing. No stall and no back-pressure.
- Reset mid-operation:
  - All state clears on that edge. Any `in_valid` on that edge is ignored, and a pending `dv` is discarded.
  - The first sample accepted after reset is phase 0.
  - `settled` stays low until 4 further outputs have been issued.

## Test plan
- **Constant input:** `in_value` = 3, `in_valid` = 1 continuously -> `out_valid` every 16 cycles; outputs 4 onward = 0x0003_0000; `settled` rises with output 4.
- **Alternating input:** `in_value` alternating 3/4 every cycle -> outputs 4 onward = 0x0003_8000 exactly.
- **Full-scale and long-run wrap:** `in_value` = 0xFFFF for 20000 samples -> every settled output = 0xFFFF_0000 despite integrator wrap.
- **Input bubbles:** `in_valid` pseudo-random with ~50% duty, `in_value` = 3/4 alternating on accepted samples -> same output sequence as the gap-free run; each `out_valid` lands 2 cycles after the 16th accepted sample.
- **Modulator loopback:** modulator target 0x0001_4000 -> mean of 64 settled outputs within +-0x40 of 0x0001_4000.
- **Reset mid-block:** `rst_n` low for 1 cycle after 37 samples -> all outputs 0 next cycle, `settled` = 0; next `out_valid` 2 cycles after the 16th post-reset sample; `settled` re-asserts on the 4th post-reset output.
